aes_key_vault: RTL and testbench
================================

Name: aes_key_vault

Overview:
- Parametrised key-storage and register-lock block.
- Holds NumKeys AES keys of KeyWords 32-bit words each behind a simple request/response register bus.
- Provides per-slot sticky locks, write-only key semantics, per-slot valid tracking and a hardware zeroize sequencer.
- Sits between the peripheral bus (AES0/REGLK window) and the AES engines.

Parameters:
- NumKeys, 3, number of key slots (1..16)
- KeyWords, 4, 32-bit words per key (4, 6 or 8)
- AddrWidth, 8, word-address width of the register window
- DataWidth, 32, bus data width (fixed 32)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- req_i  in  1  bus request
- we_i  in  1  1 = write, 0 = read
- addr_i  in  AddrWidth  word address
- wdata_i  in  32  write data
- gnt_o  out  1  request accepted
- rvalid_o  out  1  response valid
- rdata_o  out  32  read data
- err_o  out  1  error response, qualified by rvalid_o
- key_o  out  NumKeys*KeyWords*32  flattened keys; slot k occupies bits [k*KeyWords*32 +: KeyWords*32]
- key_valid_o  out  NumKeys  all words of slot written since last reset or zeroize
- busy_o  out  1  zeroize in progress

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high (clk_i, rst_i).
- Reset values: all key words = 0, locks = 0, word-written flags = 0, FSM = IDLE, all outputs 0.
- Map, with KW = NumKeys*KeyWords:
  - word k*KeyWords+w: key slot k, word w
  - KW: LOCK, bits [NumKeys-1:0]
  - KW+1: ZEROIZE, write bit0 = 1 to start
  - KW+2: STATUS, {busy, key_valid}
  - above KW+2: unmapped
- Handshake:
  - gnt_o = req_i & (state == IDLE), combinational.
  - Each granted request yields exactly one rvalid_o pulse the next cycle; rdata_o and err_o are valid in that cycle only, 0 otherwise.
  - Requests made while busy are held off (gnt_o = 0), not errored.
- Key word writes:
  - Unlocked slot: store word, set its written flag, err = 0.
  - Locked slot: no change, err = 1.
- Key word reads: always rdata = 0, err = 1 (write-only).
- LOCK register:
  - Write ORs wdata[NumKeys-1:0] into the locks (sticky); locks clear only on reset.
  - Read returns the locks, zero-extended.
- key_valid_o[k] = AND of slot k's written flags. key_o is driven continuously from storage.
- ZEROIZE read returns 0. STATUS read returns busy in bit NumKeys and key_valid in [NumKeys-1:0]. STATUS write is ignored, err = 0.
- Unmapped access: err = 1, rdata = 0, no side effects.
- Zeroize FSM:
  - IDLE -> WIPE on a granted ZEROIZE write with bit0 = 1; err = 0. The response is still issued next cycle.
  - WIPE: counter idx 0..KW-1 clears one word and its written flag per cycle, locked or not. Locks are retained.
  - WIPE -> IDLE after clearing idx = KW-1, so busy_o is high for exactly KW cycles, starting the cycle after the grant.
  - key_valid_o[k] drops the cycle after slot k's first word is cleared.
- Simultaneous events:
  - Reset has priority over everything, including mid-WIPE: immediate return to reset values.
  - A write with wdata = 0 still sets the written flag.
- Width rules: KW+2 < 2^AddrWidth, checked by an elaboration assertion. The idx counter is $clog2(KW) bits wide, minimum 1.

Test Plan:
- Reset, then write slot 0 words 0..3 = 0x11111111..0x44444444 -> gnt same cycle; rvalid next cycle, err = 0; after the 4th write key_valid_o = 3'b001 and key_o[127:0] = 0x44444444_33333333_22222222_11111111.
- Read addr 0 -> rvalid with rdata = 0, err = 1. Read STATUS -> rdata = 0x1.
- Write LOCK = 0x2, then write slot 1 word 0 = 0xDEADBEEF -> err = 1, key_o slot 1 remains 0. Write LOCK = 0x0 -> LOCK reads 0x2 (sticky).
- Fill all slots, then write ZEROIZE = 1 -> busy_o high for exactly 12 cycles; a read issued during that window is granted only after busy_o falls. Afterwards key_o = 0, key_valid_o = 0, LOCK still reads 0x2.
- Assert rst_i on WIPE cycle 5 -> next cycle busy_o = 0, LOCK = 0, all keys 0.
- Access addr 15 (unmapped, KW+3) -> err = 1, rdata = 0. Repeat with NumKeys = 2, KeyWords = 8: ZEROIZE busy lasts 16 cycles and STATUS busy is bit 2.

Source files
------------

// File: rtl/aes_key_vault.sv
// Key storage vault: write-only AES key slots with sticky per-slot locks,
// valid tracking and a word-serial hardware zeroize sequencer.
module aes_key_vault #(
    parameter int unsigned NumKeys   = 3,
    parameter int unsigned KeyWords  = 4,
    parameter int unsigned AddrWidth = 8,
    parameter int unsigned DataWidth = 32
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic                                  req_i,
    input  logic                                  we_i,
    input  logic [AddrWidth-1:0]                  addr_i,
    input  logic [DataWidth-1:0]                  wdata_i,
    output logic                                  gnt_o,
    output logic                                  rvalid_o,
    output logic [DataWidth-1:0]                  rdata_o,
    output logic                                  err_o,
    output logic [NumKeys*KeyWords*DataWidth-1:0] key_o,
    output logic [NumKeys-1:0]                    key_valid_o,
    output logic                                  busy_o
);

    localparam int unsigned KW   = NumKeys * KeyWords;
    localparam int unsigned IdxW = (KW > 1) ? $clog2(KW) : 1;

    localparam logic [AddrWidth-1:0] AddrLock   = AddrWidth'(KW);
    localparam logic [AddrWidth-1:0] AddrZero   = AddrWidth'(KW + 1);
    localparam logic [AddrWidth-1:0] AddrStatus = AddrWidth'(KW + 2);

    if (KW + 2 >= 2 ** AddrWidth) begin : g_addr_chk
        $error("aes_key_vault: register map does not fit in AddrWidth");
    end
    if (DataWidth != 32) begin : g_data_chk
        $error("aes_key_vault: DataWidth must be 32");
    end
    if (NumKeys < 1 || NumKeys > 16) begin : g_keys_chk
        $error("aes_key_vault: NumKeys must be 1..16");
    end

    typedef enum logic {S_IDLE, S_WIPE} state_e;

    state_e                      r_state, w_state_next;
    logic [IdxW-1:0]             r_idx, w_idx_next;
    logic [KW-1:0][DataWidth-1:0] r_key;
    logic [KW-1:0]               r_written;
    logic [NumKeys-1:0]          r_lock;
    logic                        r_rvalid;
    logic [DataWidth-1:0]        r_rdata;
    logic                        r_err;

    logic                        w_gnt;
    logic                        w_is_key;
    logic                        w_lock_hit;
    logic [IdxW-1:0]             w_widx;
    logic                        w_key_we;
    logic                        w_lock_we;
    logic                        w_zero_start;
    logic [DataWidth-1:0]        w_rdata;
    logic                        w_err;

    assign w_gnt       = req_i && (r_state == S_IDLE);
    assign gnt_o       = w_gnt;
    assign busy_o      = (r_state == S_WIPE);
    assign rvalid_o    = r_rvalid;
    assign rdata_o     = r_rdata;
    assign err_o       = r_err;
    assign key_o       = r_key;
    assign w_is_key    = (addr_i < AddrLock);
    assign w_widx      = IdxW'(addr_i);

    for (genvar k = 0; k < NumKeys; k++) begin : g_valid
        assign key_valid_o[k] = &r_written[k*KeyWords +: KeyWords];
    end

    // Lock of the slot the current key-word address falls in.
    always_comb begin
        w_lock_hit = 1'b0;
        for (int k = 0; k < NumKeys; k++) begin
            if (addr_i >= AddrWidth'(k * KeyWords) && addr_i < AddrWidth'((k + 1) * KeyWords))
                w_lock_hit = w_lock_hit | r_lock[k];
        end
    end

    // Register decode: response data/error and write strobes.
    always_comb begin
        w_rdata      = '0;
        w_err        = 1'b0;
        w_key_we     = 1'b0;
        w_lock_we    = 1'b0;
        w_zero_start = 1'b0;
        if (w_is_key) begin
            if (we_i && !w_lock_hit) w_key_we = w_gnt;
            else                     w_err    = 1'b1;
        end else if (addr_i == AddrLock) begin
            if (we_i) w_lock_we = w_gnt;
            else      w_rdata   = DataWidth'(r_lock);
        end else if (addr_i == AddrZero) begin
            w_zero_start = w_gnt && we_i && wdata_i[0];
        end else if (addr_i == AddrStatus) begin
            if (!we_i) w_rdata = DataWidth'({busy_o, key_valid_o});
        end else begin
            w_err = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_next;
            r_idx   <= w_idx_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        case (r_state)
            S_IDLE: begin
                if (w_zero_start) begin
                    w_state_next = S_WIPE;
                    w_idx_next   = '0;
                end
            end
            S_WIPE: begin
                if (r_idx == IdxW'(KW - 1)) begin
                    w_state_next = S_IDLE;
                    w_idx_next   = '0;
                end else begin
                    w_idx_next = r_idx + IdxW'(1);
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Storage, locks and the registered bus response.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_key     <= '0;
            r_written <= '0;
            r_lock    <= '0;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
            r_err     <= 1'b0;
        end else begin
            r_rvalid <= w_gnt;
            r_rdata  <= w_gnt ? w_rdata : '0;
            r_err    <= w_gnt && w_err;
            if (w_key_we) begin
                r_key[w_widx]     <= wdata_i;
                r_written[w_widx] <= 1'b1;
            end
            if (w_lock_we) r_lock <= r_lock | wdata_i[NumKeys-1:0];
            if (r_state == S_WIPE) begin
                r_key[r_idx]     <= '0;
                r_written[r_idx] <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_aes_key_vault.sv
// Bench for aes_key_vault: default 3x4 instance plus a 2x8 instance sharing one bus driver.
module tb_aes_key_vault;

    logic         clk = 1'b0;
    logic         rst;
    logic         req, we, sel;
    logic [7:0]   addr;
    logic [31:0]  wdata;

    logic         gnt_a, rvalid_a, err_a, busy_a;
    logic [31:0]  rdata_a;
    logic [383:0] key_a;
    logic [2:0]   kv_a;

    logic         gnt_b, rvalid_b, err_b, busy_b;
    logic [31:0]  rdata_b;
    logic [511:0] key_b;
    logic [1:0]   kv_b;

    logic         gnt, rvalid, err, busy;
    logic [31:0]  rdata;

    int           total = 0;
    int           bad   = 0;
    int           busy_cnt = 0;
    logic [32:0]  exp_q[$];

    always #5 clk = ~clk;

    aes_key_vault dut_a (
        .clk_i(clk), .rst_i(rst), .req_i(req && !sel), .we_i(we), .addr_i(addr),
        .wdata_i(wdata), .gnt_o(gnt_a), .rvalid_o(rvalid_a), .rdata_o(rdata_a),
        .err_o(err_a), .key_o(key_a), .key_valid_o(kv_a), .busy_o(busy_a)
    );

    aes_key_vault #(.NumKeys(2), .KeyWords(8)) dut_b (
        .clk_i(clk), .rst_i(rst), .req_i(req && sel), .we_i(we), .addr_i(addr),
        .wdata_i(wdata), .gnt_o(gnt_b), .rvalid_o(rvalid_b), .rdata_o(rdata_b),
        .err_o(err_b), .key_o(key_b), .key_valid_o(kv_b), .busy_o(busy_b)
    );

    assign gnt    = sel ? gnt_b    : gnt_a;
    assign rvalid = sel ? rvalid_b : rvalid_a;
    assign rdata  = sel ? rdata_b  : rdata_a;
    assign err    = sel ? err_b    : err_a;
    assign busy   = sel ? busy_b   : busy_a;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard consumer: every response must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (rvalid) begin
                if (exp_q.size() == 0) begin
                    chk("rvalid_spurious", 1, 0);
                end else begin
                    logic [32:0] e;
                    e = exp_q.pop_front();
                    chk("rdata", rdata, e[32:1]);
                    chk("err", err, e[0]);
                end
            end else begin
                chk("idle_resp", {rdata, err}, 0);
            end
            if (busy) busy_cnt++;
        end
    end

    task automatic bus(input logic w, input logic [7:0] a, input logic [31:0] d,
                       input logic [31:0] er, input logic ee, output int waits);
        req = 1'b1; we = w; addr = a; wdata = d; waits = 0;
        @(negedge clk);
        while (!gnt && waits < 200) begin
            waits++;
            @(negedge clk);
        end
        if (gnt) exp_q.push_back({er, ee});
        else     chk("gnt_timeout", 0, 1);
        @(posedge clk); #1;
        req = 1'b0; we = 1'b0;
    endtask

    task automatic drain();
        repeat (3) @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        we;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
    } vec_t;

    vec_t tbl[16];
    int   waits;

    initial begin
        tbl[0]  = '{1'b1, 8'd0,   32'h11111111, 32'h0, 1'b0};
        tbl[1]  = '{1'b1, 8'd1,   32'h22222222, 32'h0, 1'b0};
        tbl[2]  = '{1'b1, 8'd2,   32'h33333333, 32'h0, 1'b0};
        tbl[3]  = '{1'b1, 8'd3,   32'h44444444, 32'h0, 1'b0};
        tbl[4]  = '{1'b0, 8'd0,   32'h0,        32'h0, 1'b1};
        tbl[5]  = '{1'b0, 8'd14,  32'h0,        32'h1, 1'b0};
        tbl[6]  = '{1'b1, 8'd12,  32'h2,        32'h0, 1'b0};
        tbl[7]  = '{1'b1, 8'd4,   32'hDEADBEEF, 32'h0, 1'b1};
        tbl[8]  = '{1'b1, 8'd12,  32'h0,        32'h0, 1'b0};
        tbl[9]  = '{1'b0, 8'd12,  32'h0,        32'h2, 1'b0};
        tbl[10] = '{1'b0, 8'd15,  32'h0,        32'h0, 1'b1};
        tbl[11] = '{1'b1, 8'd15,  32'h5,        32'h0, 1'b1};
        tbl[12] = '{1'b0, 8'd13,  32'h0,        32'h0, 1'b0};
        tbl[13] = '{1'b1, 8'd14,  32'hFFFF,     32'h0, 1'b0};
        tbl[14] = '{1'b1, 8'd8,   32'h0,        32'h0, 1'b0};
        tbl[15] = '{1'b0, 8'd255, 32'h0,        32'h0, 1'b1};

        rst = 1'b1; req = 1'b0; we = 1'b0; sel = 1'b0; addr = '0; wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_key_a", key_a, 0);
        chk("rst_kv_a", kv_a, 0);
        chk("rst_busy_a", busy_a, 0);
        chk("rst_rvalid_a", rvalid_a, 0);
        chk("rst_key_b", key_b, 0);
        @(posedge clk); #1;

        for (int i = 0; i < 16; i++)
            bus(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].rdata, tbl[i].err, waits);
        drain();
        chk("kv_slot0", kv_a, 3'b001);
        chk("key_slot0", key_a[127:0], 128'h44444444_33333333_22222222_11111111);
        chk("key_slot1_locked", key_a[255:128], 0);
        chk("key_slot2_w0_zero", key_a[287:256], 0);

        // Finish slot 2 (word 0 already written with zero), slot 1 stays locked.
        bus(1'b1, 8'd9,  32'hA0A0A0A0, 32'h0, 1'b0, waits);
        bus(1'b1, 8'd10, 32'hB0B0B0B0, 32'h0, 1'b0, waits);
        bus(1'b1, 8'd11, 32'hC0C0C0C0, 32'h0, 1'b0, waits);
        bus(1'b0, 8'd14, 32'h0,        32'h5, 1'b0, waits);
        drain();
        chk("kv_slot0_2", kv_a, 3'b101);

        // Zeroize: busy for exactly KW cycles, a read issued meanwhile is held off.
        busy_cnt = 0;
        bus(1'b1, 8'd13, 32'h1, 32'h0, 1'b0, waits);
        bus(1'b0, 8'd12, 32'h0, 32'h2, 1'b0, waits);
        chk("zero_holdoff", waits, 12);
        drain();
        chk("zero_busy_cycles", busy_cnt, 12);
        chk("zero_key", key_a, 0);
        chk("zero_kv", kv_a, 0);

        // Reset during WIPE cycle 5 aborts the sweep and clears the locks.
        bus(1'b1, 8'd11, 32'h12345678, 32'h0, 1'b0, waits);
        bus(1'b1, 8'd13, 32'h1,        32'h0, 1'b0, waits);
        repeat (4) @(posedge clk);
        #1;
        @(negedge clk);
        chk("wipe5_busy", busy_a, 1);
        chk("wipe5_word11", key_a[383:352], 32'h12345678);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_wipe_busy", busy_a, 0);
        chk("rst_wipe_key", key_a, 0);
        @(posedge clk); #1;
        bus(1'b0, 8'd12, 32'h0, 32'h0, 1'b0, waits);
        drain();

        // 2x8 instance: map LOCK=16 ZERO=17 STATUS=18.
        sel = 1'b1;
        for (int w = 0; w < 8; w++)
            bus(1'b1, 8'(w), 32'h100 + 32'(w), 32'h0, 1'b0, waits);
        bus(1'b0, 8'd18, 32'h0, 32'h1, 1'b0, waits);
        bus(1'b0, 8'd19, 32'h0, 32'h0, 1'b1, waits);
        drain();
        chk("b_kv", kv_b, 2'b01);
        chk("b_key_w7", key_b[255:224], 32'h107);
        busy_cnt = 0;
        bus(1'b1, 8'd17, 32'h1, 32'h0, 1'b0, waits);
        bus(1'b0, 8'd18, 32'h0, 32'h0, 1'b0, waits);
        chk("b_zero_holdoff", waits, 16);
        drain();
        chk("b_zero_busy_cycles", busy_cnt, 16);
        chk("b_zero_key", key_b, 0);

        chk("sb_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
